// File: rtl/light_separator_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : light_separator_apb_master
// Description : APB initiator for the Light Separator register port. Register
//               commands arrive on a valid/ready port, are buffered in a small
//               FIFO and issued as back-to-back two-cycle APB transfers
//               (SETUP, ACCESS) with no wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module light_separator_apb_master #(
  parameter int Amba_Addr_Depth = 20,
  parameter int Amba_Word       = 16,
  parameter int CMD_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [Amba_Addr_Depth-1:0] cmd_addr,
  input  logic [Amba_Word-1:0]       cmd_wdata,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic [Amba_Word-1:0]       PRDATA,
  output logic                       done,
  output logic                       done_read,
  output logic [Amba_Word-1:0]       rd_data,
  output logic                       busy
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = 1 + Amba_Addr_Depth + Amba_Word;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CMD_W-1:0]           mem_q [CMD_DEPTH];
  logic [CMD_W-1:0]           mem_d [CMD_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [Amba_Addr_Depth-1:0] paddr_q, paddr_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [Amba_Word-1:0]       pwdata_q, pwdata_d;
  logic                       done_q, done_d;
  logic                       done_read_q, done_read_d;
  logic [Amba_Word-1:0]       rd_data_q, rd_data_d;

  logic                       fifo_full, fifo_empty, push, pop;
  logic                       head_write;
  logic [Amba_Addr_Depth-1:0] head_addr;
  logic [Amba_Word-1:0]       head_wdata;

  // FIFO status; no command is accepted while reset is held
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    cmd_ready  = rst && !fifo_full;
    push       = cmd_valid && cmd_ready;
    {head_write, head_addr, head_wdata} = mem_q[rd_ptr_q];
  end

  // FIFO storage, pointers and occupancy; push and pop together leave count unchanged
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // APB sequencer: next state and registered bus outputs
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    done_read_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          paddr_d   = head_addr;
          pwrite_d  = head_write;
          pwdata_d  = head_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        done_d      = 1'b1;
        done_read_d = !pwrite_q;
        if (!pwrite_q) begin
          rd_data_d = PRDATA;
        end
        penable_d = 1'b0;
        if (!fifo_empty) begin
          // chain straight into the next SETUP with no idle cycle
          pop      = 1'b1;
          paddr_d  = head_addr;
          pwrite_d = head_write;
          pwdata_d = head_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          psel_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any transfer and flushes the FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      done_q      <= 1'b0;
      done_read_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      done_q      <= done_d;
      done_read_q <= done_read_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Command storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output drive
  always_comb begin
    PADDR     = paddr_q;
    PSEL      = psel_q;
    PENABLE   = penable_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    done      = done_q;
    done_read = done_read_q;
    rd_data   = rd_data_q;
    busy      = (state_q != ST_IDLE) || !fifo_empty;
  end

endmodule
`default_nettype wire

// File: tb/tb_light_separator_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_separator_apb_master
// Description : Directed self-checking bench for light_separator_apb_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_separator_apb_master;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          done;
  logic          done_read;
  logic [DW-1:0] rd_data;
  logic          busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // transfers seen in ACCESS, in completion order
  logic [AW-1:0] log_addr [64];
  logic [DW-1:0] log_data [64];
  logic          log_wr   [64];
  int            log_n = 0;

  always #5 clk = ~clk;

  light_separator_apb_master #(
    .Amba_Addr_Depth(AW),
    .Amba_Word      (DW),
    .CMD_DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .done     (done),
    .done_read(done_read),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // slave: read data only during a read ACCESS phase
  assign PRDATA = (PSEL && PENABLE && !PWRITE) ?
                  ((PADDR == 20'h00004) ? 16'hBEEF :
                   (PADDR == 20'h00008) ? 16'hCAFE : 16'h5A5A) : 16'h0000;

  always @(posedge clk) begin
    if (rst && PSEL && PENABLE && log_n < 64) begin
      log_addr[log_n] = PADDR;
      log_data[log_n] = PWDATA;
      log_wr[log_n]   = PWRITE;
      log_n           = log_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_one(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  int sent, dcnt, gap, tog, base;
  logic saw_full, started, prev_psel, prev_pen, last_ready;

  initial begin
    // ---------------- 1) reset with a command offered ----------------
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 20'h00003;
    cmd_wdata = 16'h0007;
    tick(); tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_apb", {PSEL, PENABLE, PWRITE}, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_done", {done, done_read, busy}, 0);
    check("rst_rd_data", rd_data, 0);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    tick();
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_psel", PSEL, 0);

    // ---------------- 2) single write 0x00010 <= 0x1234 ----------------
    push_one(1'b1, 20'h00010, 16'h1234);
    check("wr_e0_busy", busy, 1);
    check("wr_e0_psel", PSEL, 0);
    tick();
    check("wr_e1_sel_en", {PSEL, PENABLE, PWRITE}, 3'b101);
    check("wr_e1_paddr", PADDR, 20'h00010);
    check("wr_e1_pwdata", PWDATA, 16'h1234);
    check("wr_e1_done", done, 0);
    tick();
    check("wr_e2_sel_en", {PSEL, PENABLE, PWRITE}, 3'b111);
    check("wr_e2_paddr", PADDR, 20'h00010);
    check("wr_e2_pwdata", PWDATA, 16'h1234);
    check("wr_e2_done", done, 0);
    tick();
    check("wr_e3_done", {done, done_read}, 2'b10);
    check("wr_e3_sel_en", {PSEL, PENABLE}, 2'b00);
    tick();
    check("wr_e4_done", done, 0);
    check("wr_e4_busy", busy, 0);
    check("wr_e4_hold", {PADDR, PWDATA}, {20'h00010, 16'h1234});

    // ---------------- 3) single read 0x00004 -> 0xBEEF ----------------
    push_one(1'b0, 20'h00004, 16'h0000);
    tick();
    check("rd_e1_sel_en", {PSEL, PENABLE, PWRITE}, 3'b100);
    check("rd_e1_paddr", PADDR, 20'h00004);
    tick();
    check("rd_e2_sel_en", {PSEL, PENABLE}, 2'b11);
    tick();
    check("rd_e3_done", {done, done_read}, 2'b11);
    check("rd_e3_rd_data", rd_data, 16'hBEEF);
    tick();
    check("rd_e4_done", {done, done_read}, 2'b00);
    check("rd_e4_rd_data_held", rd_data, 16'hBEEF);

    // ---------- 4) write burst: pushes outpace the two-cycle drain ----------
    base = log_n; sent = 0; dcnt = 0; gap = 0; tog = 0;
    saw_full = 1'b0; started = 1'b0; prev_psel = 1'b0; prev_pen = 1'b0; last_ready = 1'b0;
    for (int cyc = 0; cyc < 60 && dcnt < 8; cyc++) begin
      if (done) dcnt++;
      if (PSEL) started = 1'b1;
      if (started && dcnt < 8 && !PSEL) gap++;
      if (PSEL && prev_psel && (PENABLE == prev_pen)) tog++;
      prev_psel = PSEL;
      prev_pen  = PENABLE;
      if (cmd_valid && last_ready) sent++;
      if (sent < 8) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 20'h00100 + 20'(sent);
        cmd_wdata = 16'hA000 + 16'(sent);
      end else begin
        cmd_valid = 1'b0;
      end
      last_ready = cmd_ready;
      if (cmd_valid && !cmd_ready) saw_full = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("burst_done_pulses", dcnt, 8);
    check("burst_sent", sent, 8);
    check("burst_ready_dropped", saw_full, 1);
    check("burst_psel_gap", gap, 0);
    check("burst_penable_toggle", tog, 0);
    check("burst_logged", log_n - base, 8);
    for (int i = 0; i < 8; i++) begin
      check("burst_order", {log_wr[base+i], log_addr[base+i], log_data[base+i]},
            {1'b1, 20'h00100 + 20'(i), 16'hA000 + 16'(i)});
    end
    check("burst_idle_busy", busy, 0);

    // ---------------- 5) write then read, back to back ----------------
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00020; cmd_wdata = 16'h55AA;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00008; cmd_wdata = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    check("wr_rd_w_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b101, 20'h00020});
    tick();
    check("wr_rd_w_access", {PSEL, PENABLE, PWRITE, PADDR}, {3'b111, 20'h00020});
    tick();
    check("wr_rd_w_done", {done, done_read}, 2'b10);
    check("wr_rd_r_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 20'h00008});
    tick();
    check("wr_rd_r_access", {PSEL, PENABLE, PWRITE, PADDR}, {3'b110, 20'h00008});
    tick();
    check("wr_rd_r_done", {done, done_read}, 2'b11);
    check("wr_rd_r_data", rd_data, 16'hCAFE);
    check("wr_rd_end_psel", PSEL, 0);

    // ------------- 6) reset during a read SETUP with two queued -------------
    push_one(1'b0, 20'h00004, 16'h0000);
    push_one(1'b0, 20'h00008, 16'h0000);
    push_one(1'b0, 20'h0000C, 16'h0000);
    push_one(1'b0, 20'h00004, 16'h0000);
    check("abort_in_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 20'h00008});
    rst = 1'b0;
    tick();
    check("abort_rst_apb", {PSEL, PENABLE, done, done_read, busy}, 0);
    check("abort_rst_rd_data", rd_data, 0);
    rst = 1'b1;
    tick();
    check("abort_post_busy", busy, 0);
    check("abort_post_done", {done, PSEL}, 0);
    tick();
    check("abort_post2", {done, PSEL, busy}, 0);
    check("abort_post_ready", cmd_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
